// File: rtl/regfile_scoreboard.sv
// Integer register file with a per-register busy scoreboard, same-cycle writeback
// forwarding on the read ports and a registered count of outstanding producers.
module regfile_scoreboard #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NR    = 2,
  parameter  int NW    = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NW-1:0]     w_valid,
  input  logic [NW*AW-1:0]  w_ad,
  input  logic [NW*XLEN-1:0] w_data,
  input  logic [NR-1:0]     r_valid,
  input  logic [NR*AW-1:0]  r_ad,
  output logic [NR-1:0]     r_rdy,
  output logic [NR*XLEN-1:0] r_data,
  input  logic              rsv_valid,
  input  logic [AW-1:0]     rsv_ad,
  output logic              rsv_ready,
  output logic [AW:0]       busy_cnt
);

  localparam int CW = AW + 1;

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [CW-1:0]    r_cnt;
  logic [XLEN-1:0]  r_rd [NR];

  logic [AW-1:0]    w_wad  [NW];
  logic [XLEN-1:0]  w_wdat [NW];
  logic [AW-1:0]    w_rad  [NR];
  logic [NREGS-1:0] w_busy_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_rsv_hit;
  logic             w_rsv_take;

  generate
    for (genvar gi = 0; gi < NW; gi++) begin : g_wr_unpack
      assign w_wad[gi]  = w_ad[gi*AW +: AW];
      assign w_wdat[gi] = w_data[gi*XLEN +: XLEN];
    end
  endgenerate

  // Read ports: forward any same-cycle writeback (last matching port wins)
  generate
    for (genvar gi = 0; gi < NR; gi++) begin : g_rd
      logic            w_hit;
      logic [XLEN-1:0] w_fwd;

      assign w_rad[gi] = r_ad[gi*AW +: AW];

      always_comb begin
        w_hit = 1'b0;
        w_fwd = r_regs[w_rad[gi]];
        for (int i = 0; i < NW; i++) begin
          if (w_valid[i] && (w_wad[i] == w_rad[gi])) begin
            w_hit = 1'b1;
            w_fwd = w_wdat[i];
          end
        end
        if (w_rad[gi] == '0) w_fwd = '0;
      end

      assign r_rdy[gi] = (w_rad[gi] == '0) || !r_busy[w_rad[gi]] || w_hit;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          r_rd[gi] <= '0;
        else if (r_valid[gi])
          r_rd[gi] <= w_fwd;
      end

      assign r_data[gi*XLEN +: XLEN] = r_rd[gi];
    end
  endgenerate

  always_comb begin
    w_rsv_hit = 1'b0;
    for (int i = 0; i < NW; i++) begin
      if (w_valid[i] && (w_wad[i] == rsv_ad)) w_rsv_hit = 1'b1;
    end
  end

  assign rsv_ready  = (rsv_ad == '0) || !r_busy[rsv_ad] || w_rsv_hit;
  assign w_rsv_take = rsv_valid && rsv_ready && (rsv_ad != '0);

  // Reserve is applied after writeback clears so a new producer keeps the bit
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < NW; i++) begin
      if (w_valid[i]) w_busy_nxt[w_wad[i]] = 1'b0;
    end
    if (w_rsv_take) w_busy_nxt[rsv_ad] = 1'b1;
    w_busy_nxt[0] = 1'b0;
    w_cnt_nxt = '0;
    for (int k = 0; k < NREGS; k++) begin
      w_cnt_nxt = w_cnt_nxt + CW'(w_busy_nxt[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
    end else begin
      for (int i = 0; i < NW; i++) begin
        if (w_valid[i] && (w_wad[i] != '0)) r_regs[w_wad[i]] <= w_wdat[i];
      end
    end
  end

  assign busy_cnt = r_cnt;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Table-driven bench for regfile_scoreboard (NW=2, NR=2): read data expectations are
// queued when a read is driven and checked one cycle later.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  w_valid;
  logic [9:0]  w_ad;
  logic [63:0] w_data;
  logic [1:0]  r_valid;
  logic [9:0]  r_ad;
  logic [1:0]  r_rdy;
  logic [63:0] r_data;
  logic        rsv_valid;
  logic [4:0]  rsv_ad;
  logic        rsv_ready;
  logic [5:0]  busy_cnt;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .NR(2), .NW(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .w_valid  (w_valid),
    .w_ad     (w_ad),
    .w_data   (w_data),
    .r_valid  (r_valid),
    .r_ad     (r_ad),
    .r_rdy    (r_rdy),
    .r_data   (r_data),
    .rsv_valid(rsv_valid),
    .rsv_ad   (rsv_ad),
    .rsv_ready(rsv_ready),
    .busy_cnt (busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wv;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [1:0]  rv;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        sv;
    logic [4:0]  sa;
    logic [1:0]  e_rdy;
    logic        e_srdy;
    logic [5:0]  e_cnt;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
  } vec_t;

  typedef struct {
    int          port;
    logic [31:0] exp;
    string       tag;
  } rd_t;

  rd_t  rd_q[$];
  vec_t tbl[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic vec_t idle();
    vec_t v;
    v = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0,
          2'b11, 1'b1, 6'd0, 32'h0, 32'h0};
    return v;
  endfunction

  task automatic drive_idle();
    w_valid = '0; w_ad = '0; w_data = '0;
    r_valid = '0; r_ad = '0;
    rsv_valid = 1'b0; rsv_ad = '0;
  endtask

  task automatic apply(input vec_t v, input string tag);
    rd_t e;
    @(negedge clk);
    w_valid   = v.wv;
    w_ad      = {v.wa1, v.wa0};
    w_data    = {v.wd1, v.wd0};
    r_valid   = v.rv;
    r_ad      = {v.ra1, v.ra0};
    rsv_valid = v.sv;
    rsv_ad    = v.sa;
    #1;
    chk({tag, " r_rdy"}, 64'(r_rdy), 64'(v.e_rdy));
    chk({tag, " rsv_ready"}, 64'(rsv_ready), 64'(v.e_srdy));
    if (v.rv[0]) begin
      e.port = 0; e.exp = v.e_rd0; e.tag = {tag, " r_data0"};
      rd_q.push_back(e);
    end
    if (v.rv[1]) begin
      e.port = 1; e.exp = v.e_rd1; e.tag = {tag, " r_data1"};
      rd_q.push_back(e);
    end
    @(posedge clk);
    #1;
    while (rd_q.size() > 0) begin
      e = rd_q.pop_front();
      chk(e.tag, 64'(r_data[e.port*32 +: 32]), 64'(e.exp));
    end
    chk({tag, " busy_cnt"}, 64'(busy_cnt), 64'(v.e_cnt));
  endtask

  initial begin
    vec_t v;
    // wv wa0 wd0 wa1 wd1 | rv ra0 ra1 | sv sa | e_rdy e_srdy e_cnt e_rd0 e_rd1
    tbl[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 2'b11, 1'b1, 6'd0, 32'h0, 32'h0};
    tbl[1]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd0, 1'b0, 5'd0, 2'b11, 1'b1, 6'd0, 32'hDEADBEEF, 32'h0};
    tbl[2]  = '{2'b01, 5'd0, 32'h12345678, 5'd0, 32'h0, 2'b11, 5'd0, 5'd0, 1'b0, 5'd0, 2'b11, 1'b1, 6'd0, 32'h0, 32'h0};
    tbl[3]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd7, 5'd0, 1'b1, 5'd7, 2'b11, 1'b1, 6'd1, 32'h0, 32'h0};
    tbl[4]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd7, 5'd5, 1'b0, 5'd0, 2'b10, 1'b1, 6'd1, 32'h0, 32'hDEADBEEF};
    tbl[5]  = '{2'b10, 5'd0, 32'h0, 5'd7, 32'hA5A5A5A5, 2'b01, 5'd7, 5'd0, 1'b0, 5'd0, 2'b11, 1'b1, 6'd0, 32'hA5A5A5A5, 32'h0};
    tbl[6]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd3, 2'b11, 1'b1, 6'd1, 32'h0, 32'h0};
    tbl[7]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd3, 2'b11, 1'b0, 6'd1, 32'h0, 32'h0};
    tbl[8]  = '{2'b01, 5'd3, 32'h33, 5'd0, 32'h0, 2'b10, 5'd0, 5'd3, 1'b1, 5'd3, 2'b11, 1'b1, 6'd1, 32'h0, 32'h33};
    tbl[9]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd3, 5'd0, 1'b0, 5'd0, 2'b10, 1'b1, 6'd1, 32'h33, 32'h0};
    tbl[10] = '{2'b11, 5'd9, 32'h1, 5'd9, 32'h2, 2'b10, 5'd0, 5'd9, 1'b0, 5'd0, 2'b11, 1'b1, 6'd1, 32'h0, 32'h2};
    tbl[11] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd9, 5'd0, 1'b0, 5'd0, 2'b11, 1'b1, 6'd1, 32'h2, 32'h0};
    tbl[12] = '{2'b11, 5'd3, 32'h44, 5'd10, 32'h10, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 2'b11, 1'b1, 6'd0, 32'h0, 32'h0};
    tbl[13] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd10, 1'b0, 5'd0, 2'b11, 1'b1, 6'd0, 32'h44, 32'h10};
    tbl[14] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b10, 5'd0, 5'd0, 1'b1, 5'd0, 2'b11, 1'b1, 6'd0, 32'h0, 32'h0};

    rst_n = 1'b0;
    drive_idle();
    #12;
    chk("reset busy_cnt", 64'(busy_cnt), 64'd0);
    chk("reset r_data", r_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 15; n++) apply(tbl[n], $sformatf("vec%0d", n));

    // port 0 was not read by the last vector, so it must still hold x3
    chk("hold r_data0", 64'(r_data[31:0]), 64'h44);

    // reserve x1..x4, then retire x2
    for (int k = 1; k <= 4; k++) begin
      v = idle(); v.sv = 1'b1; v.sa = 5'(k); v.e_cnt = 6'(k);
      apply(v, $sformatf("rsv x%0d", k));
    end
    v = idle(); v.wv = 2'b01; v.wa0 = 5'd2; v.wd0 = 32'h55; v.e_cnt = 6'd3;
    apply(v, "wb x2");
    v = idle(); v.rv = 2'b11; v.ra0 = 5'd10; v.ra1 = 5'd2; v.e_cnt = 6'd3;
    v.e_rd0 = 32'h10; v.e_rd1 = 32'h55;
    apply(v, "pre-reset read");

    // reset asserted mid-cycle with a read and a reserve in flight
    @(negedge clk);
    r_valid = 2'b01; r_ad = {5'd0, 5'd10};
    rsv_valid = 1'b1; rsv_ad = 5'd6;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset busy_cnt", 64'(busy_cnt), 64'd0);
    chk("async reset r_data", r_data, 64'd0);
    @(posedge clk);
    #1;
    chk("in reset busy_cnt", 64'(busy_cnt), 64'd0);
    chk("in reset r_data", r_data, 64'd0);
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;

    v = idle(); v.rv = 2'b11; v.ra0 = 5'd2; v.ra1 = 5'd10;
    apply(v, "post-reset read");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of two, 2..64); AW = log2(NREGS).
REQ-003 SHALL have parameter NR, default 2, read-port count (1..4).
REQ-004 SHALL have parameter NW, default 1, write-port count (1..2).
REQ-005 SHALL have port: clk  in  1  single clock, all state updates on rising edge.
REQ-006 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port: w_valid  in  NW  per-port writeback strobe.
REQ-008 SHALL have port: w_ad  in  NW*AW  writeback addresses.
REQ-009 SHALL have port: w_data  in  NW*XLEN  writeback data.
REQ-010 SHALL have port: r_valid  in  NR  per-port read request.
REQ-011 SHALL have port: r_ad  in  NR*AW  read addresses.
REQ-012 SHALL have port: r_rdy  out  NR  combinational operand-available flag per port.
REQ-013 SHALL have port: r_data  out  NR*XLEN  registered read data.
REQ-014 SHALL have port: rsv_valid  in  1  request to reserve destination (mark busy).
REQ-015 SHALL have port: rsv_ad  in  AW  destination to reserve.
REQ-016 SHALL have port: rsv_ready  out  1  combinational reserve-accept flag.
REQ-017 SHALL have port: busy_cnt  out  AW+1  registered count of busy registers.

Function
REQ-018 SHALL hardwire register 0: writes ignored, reads return 0, never busy, reserve always accepted with no effect.
REQ-019 SHALL write w_data[i] to register w_ad[i] at the rising edge where w_valid[i]=1, and clear its busy bit.
REQ-020 SHALL, when two write ports target the same address in one cycle, store data from the higher-indexed port.
REQ-021 SHALL sample r_ad[j] when r_valid[j]=1 and present the value on r_data[j] one cycle later (latency 1); r_data[j] holds its value when r_valid[j]=0.
REQ-022 SHALL forward same-cycle writeback: a read sampled in the cycle a matching write occurs returns the new data (higher port wins), never stale array content.
REQ-023 SHALL drive r_rdy[j]=1 when r_ad[j]=0, or busy[r_ad[j]]=0, or a same-cycle w_valid targets r_ad[j]; else 0; r_rdy does not gate the read.
REQ-024 SHALL drive rsv_ready=1 when rsv_ad=0, or busy[rsv_ad]=0, or a same-cycle w_valid targets rsv_ad (WAW protection).
REQ-025 SHALL set busy[rsv_ad] at the edge where rsv_valid=1, rsv_ready=1 and rsv_ad!=0.
REQ-026 SHALL, on simultaneous accepted reserve and writeback to the same address, leave busy set (new producer wins) while still writing the data.
REQ-027 SHALL leave busy unchanged and write nothing when rsv_valid=1 with rsv_ready=0.
REQ-028 SHALL update busy_cnt each edge to the population count of the next busy vector; never exceeds NREGS-1.
REQ-029 SHALL treat writeback to a non-busy register as a plain write (no error, busy stays 0).

Reset
REQ-030 SHALL, while rst_n=0, clear all registers, all busy bits, r_data to 0 and busy_cnt to 0, independent of clk.
REQ-031 SHALL discard any in-flight read or reserve on reset assertion; first valid read after release returns 0 for any address.

Verification
REQ-032 SHALL cover: write x5=0xDEADBEEF, next cycle read x5 -> r_data=0xDEADBEEF one cycle after request.
REQ-033 SHALL cover: write x0=0x12345678, read x0 -> r_data=0, r_rdy=1, busy_cnt=0.
REQ-034 SHALL cover: reserve x7 -> busy_cnt=1, r_rdy for x7=0; writeback x7=0xA5A5A5A5 with read x7 same cycle -> r_rdy=1, r_data=0xA5A5A5A5 next cycle, busy_cnt=0.
REQ-035 SHALL cover: x3 busy, reserve x3 -> rsv_ready=0, busy_cnt unchanged; same reserve with writeback x3 same cycle -> accepted, busy stays 1.
REQ-036 SHALL cover (NW=2): both ports write x9, port0=0x1, port1=0x2 -> read x9 returns 0x2.
REQ-037 SHALL cover: reserve x1..x4, write x2=0x55, assert rst_n=0 mid-cycle -> busy_cnt=0 and r_data=0 immediately; read x2 after release -> 0.
